// File: rtl/hit_scorer_pkg.sv
// hit_scorer shared types and constants.
// State encoding, position count and game constants.
package hit_scorer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_WINDOW,
    S_JUDGED,
    S_DONE
  } state_e;

  localparam int NUM_POS_DEF = 9;

  localparam int PTS_NORMAL   = 25;
  localparam int PTS_EXTENDED = 50;

  localparam int WEIGHT_W = 4;

  function automatic logic [WEIGHT_W-1:0] nz_weight(
    input logic [WEIGHT_W-1:0] v
  );
    return (v == '0) ? WEIGHT_W'(1) : v;
  endfunction

endpackage

// File: rtl/hit_scorer_if.sv
// hit_scorer game bus.
// Settings, light/key inputs and score outputs.
interface hit_scorer_if #(
  parameter int POS_W   = 4,
  parameter int SCORE_W = 8,
  parameter int ROUND_W = 6
);

  logic               start;
  logic               deathmatch;
  logic [ROUND_W-1:0] target_rounds;
  logic [3:0]         weight;
  logic               light_on;
  logic [POS_W-1:0]   light_pos;
  logic               key_valid;
  logic [POS_W-1:0]   key_pos;

  logic [SCORE_W-1:0] score;
  logic [ROUND_W-1:0] hits;
  logic [ROUND_W-1:0] misses;
  logic [ROUND_W-1:0] rounds;
  logic               hit_pulse;
  logic               miss_pulse;
  logic               busy;
  logic               game_over;

  modport master (
    output start,
    output deathmatch,
    output target_rounds,
    output weight,
    output light_on,
    output light_pos,
    output key_valid,
    output key_pos,
    input  score,
    input  hits,
    input  misses,
    input  rounds,
    input  hit_pulse,
    input  miss_pulse,
    input  busy,
    input  game_over
  );

  modport slave (
    input  start,
    input  deathmatch,
    input  target_rounds,
    input  weight,
    input  light_on,
    input  light_pos,
    input  key_valid,
    input  key_pos,
    output score,
    output hits,
    output misses,
    output rounds,
    output hit_pulse,
    output miss_pulse,
    output busy,
    output game_over
  );

endinterface

// File: rtl/hit_scorer_sat_add.sv
// Saturating unsigned adder.
// Clamps to all-ones instead of wrapping.
module sat_add #(
  parameter int A_W = 8,
  parameter int B_W = 4
) (
  input  logic [A_W-1:0] a_i,
  input  logic [B_W-1:0] b_i,
  output logic [A_W-1:0] sum_o
);

  logic [A_W:0] full;

  // Extra carry bit flags overflow.
  always_comb begin
    full  = {1'b0, a_i} + (A_W+1)'(b_i);
    sum_o = full[A_W] ? '1 : full[A_W-1:0];
  end

endmodule

// File: rtl/hit_scorer.sv
// Whack-a-mole round judge.
// Pairs light windows with key presses and keeps score.
module hit_scorer
  import hit_scorer_pkg::*;
#(
  parameter int POS_W   = 4,
  parameter int NUM_POS = NUM_POS_DEF,
  parameter int SCORE_W = 8,
  parameter int ROUND_W = 6
) (
  input logic       clk,
  input logic       resetn,
  hit_scorer_if.slave bus
);

  localparam logic [POS_W:0] NUM_POS_L = (POS_W+1)'(NUM_POS);

  state_e             state_q;
  logic               light_q;
  logic               dm_q;
  logic [ROUND_W-1:0] target_q;
  logic [3:0]         weight_q;
  logic [SCORE_W-1:0] score_q;
  logic [ROUND_W-1:0] hits_q;
  logic [ROUND_W-1:0] misses_q;
  logic [ROUND_W-1:0] rounds_q;
  logic               round_miss_q;
  logic               hit_pulse_q;
  logic               miss_pulse_q;
  logic               busy_q;
  logic               game_over_q;

  logic               rise;
  logic               fall;
  logic               key_hit;
  logic               end_miss;
  logic               last_round;
  logic [ROUND_W-1:0] rounds_d;
  logic [ROUND_W-1:0] hits_d;
  logic [ROUND_W-1:0] misses_d;
  logic [ROUND_W-1:0] target_d;
  logic [3:0]         weight_d;
  logic [SCORE_W-1:0] score_d;

  sat_add #(
    .A_W (SCORE_W),
    .B_W (4)
  ) u_sat_add (
    .a_i   (score_q),
    .b_i   (weight_q),
    .sum_o (score_d)
  );

  // Edge detect, judge decode and round-end decision.
  always_comb begin
    rise     = bus.light_on & ~light_q;
    fall     = ~bus.light_on & light_q;
    key_hit  = (bus.key_pos == bus.light_pos) &&
               ({1'b0, bus.key_pos} < NUM_POS_L);
    rounds_d = rounds_q + ROUND_W'(1);
    hits_d   = hits_q + ROUND_W'(1);
    misses_d = misses_q + ROUND_W'(1);
    end_miss = (state_q == S_WINDOW) | round_miss_q;
    last_round = (rounds_d == target_q) | (dm_q & end_miss);
    target_d = (bus.target_rounds == '0) ? ROUND_W'(1)
                                         : bus.target_rounds;
    weight_d = nz_weight(bus.weight);
  end

  // Game FSM with counters and registered strobes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      light_q      <= 1'b0;
      dm_q         <= 1'b0;
      target_q     <= '0;
      weight_q     <= '0;
      score_q      <= '0;
      hits_q       <= '0;
      misses_q     <= '0;
      rounds_q     <= '0;
      round_miss_q <= 1'b0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      busy_q       <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      light_q      <= bus.light_on;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      if (bus.start) begin
        state_q      <= S_ARMED;
        dm_q         <= bus.deathmatch;
        target_q     <= target_d;
        weight_q     <= weight_d;
        score_q      <= '0;
        hits_q       <= '0;
        misses_q     <= '0;
        rounds_q     <= '0;
        round_miss_q <= 1'b0;
        busy_q       <= 1'b1;
        game_over_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_ARMED: begin
            if (rise) begin
              state_q <= S_WINDOW;
            end
          end
          S_WINDOW: begin
            if (fall) begin
              misses_q     <= misses_d;
              miss_pulse_q <= 1'b1;
              rounds_q     <= rounds_d;
              if (last_round) begin
                state_q     <= S_DONE;
                busy_q      <= 1'b0;
                game_over_q <= 1'b1;
              end else begin
                state_q <= S_ARMED;
              end
            end else if (bus.key_valid) begin
              state_q <= S_JUDGED;
              if (key_hit) begin
                score_q      <= score_d;
                hits_q       <= hits_d;
                hit_pulse_q  <= 1'b1;
                round_miss_q <= 1'b0;
              end else begin
                misses_q     <= misses_d;
                miss_pulse_q <= 1'b1;
                round_miss_q <= 1'b1;
              end
            end
          end
          S_JUDGED: begin
            if (fall) begin
              rounds_q <= rounds_d;
              if (last_round) begin
                state_q     <= S_DONE;
                busy_q      <= 1'b0;
                game_over_q <= 1'b1;
              end else begin
                state_q <= S_ARMED;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Everything leaving the block is a flop.
  always_comb begin
    bus.score      = score_q;
    bus.hits       = hits_q;
    bus.misses     = misses_q;
    bus.rounds     = rounds_q;
    bus.hit_pulse  = hit_pulse_q;
    bus.miss_pulse = miss_pulse_q;
    bus.busy       = busy_q;
    bus.game_over  = game_over_q;
  end

endmodule
